booth_mult_seq: RTL

Sequential radix-4 modified Booth multiplier for signed operands.
Sits directly upstream of the binary-to-decimal converter and drives its 16-bit signed bin_i input with product_o.
Accepts one operand pair per start handshake and retires two multiplier bits per clock.
Holds the product stable until the next accepted start, so the display path downstream always sees a steady value.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_pp_sel.sv | 29 ++
 rtl/booth_mult_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2} pp_e;

  // Iterations needed: two multiplier bits retired per step.
  function automatic int unsigned booth_iters(input int unsigned width);
    return width / 2;
  endfunction

  // Radix-4 Booth recoding of {Q[2:1], Q[0]}.
  function automatic pp_e booth_recode(input logic [2:0] trip);
    pp_e sel;
    sel = PP_ZERO;
    case (trip)
      3'b001, 3'b010: sel = PP_POS1;
      3'b011:         sel = PP_POS2;
      3'b100:         sel = PP_NEG2;
      3'b101, 3'b110: sel = PP_NEG1;
      default:        sel = PP_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Partial-product selector: maps a Booth triplet onto 0, +/-M or +/-2M.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       i_triplet,
  input  logic [WIDTH+1:0] i_m,
  output logic [WIDTH+1:0] o_pp
);

  localparam int unsigned PW = WIDTH + 2;

  logic [PW-1:0] w_m2;

  assign w_m2 = {i_m[PW-2:0], 1'b0};

  always_comb begin
    o_pp = '0;
    unique case (booth_recode(i_triplet))
      PP_POS1: o_pp = i_m;
      PP_POS2: o_pp = w_m2;
      PP_NEG1: o_pp = -i_m;
      PP_NEG2: o_pp = -w_m2;
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth signed multiplier; product held until next completion.
// Optional BOOTH_ZERO_SKIP_EN: zero operand jumps straight to DONE with product 0.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned PW   = WIDTH + 2;
  localparam int unsigned QW   = WIDTH + 1;
  localparam int unsigned ITER = booth_iters(WIDTH);
  localparam int unsigned CW   = $clog2(ITER + 1);

  state_e             r_state, w_state_nxt;
  logic [PW-1:0]      r_p, w_p_nxt;
  logic [QW-1:0]      r_q, w_q_nxt;
  logic [PW-1:0]      r_m, w_m_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [2*WIDTH-1:0] r_product, w_prod_nxt;

  logic [PW-1:0] w_pp;
  logic [PW-1:0] w_sum;
  logic [PW-1:0] w_p_shift;
  logic [QW-1:0] w_q_shift;

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .i_triplet (r_q[2:0]),
    .i_m       (r_m),
    .o_pp      (w_pp)
  );

  // One iteration: accumulate, then arithmetic shift {P,Q} right by two.
  assign w_sum     = r_p + w_pp;
  assign w_p_shift = {{2{w_sum[PW-1]}}, w_sum[PW-1:2]};
  assign w_q_shift = {w_sum[1:0], r_q[QW-1:2]};

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_q_nxt     = r_q;
    w_m_nxt     = r_m;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_prod_nxt  = r_product;
    unique case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (start_i) begin
`ifdef BOOTH_ZERO_SKIP_EN
          if (a_i == '0 || b_i == '0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_prod_nxt  = '0;
            w_cnt_nxt   = '0;
          end else
`endif
          begin
            w_state_nxt = CALC;
            w_busy_nxt  = 1'b1;
            w_m_nxt     = {{2{a_i[WIDTH-1]}}, a_i};
            w_q_nxt     = {b_i, 1'b0};
            w_p_nxt     = '0;
            w_cnt_nxt   = '0;
          end
        end
      end
      CALC: begin
        w_p_nxt   = w_p_shift;
        w_q_nxt   = w_q_shift;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(ITER - 1)) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          w_prod_nxt  = {w_p_shift[WIDTH-1:0], w_q_shift[QW-1:1]};
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_p       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_p       <= w_p_nxt;
      r_q       <= w_q_nxt;
      r_m       <= w_m_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_product <= w_prod_nxt;
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign product_o = r_product;

endmodule
